// File: rtl/txrx_seq.sv
// Autonomous txrx bus initiator: one packet per command (poll, program, stream, start, poll).
// Build option: TXRX_SEQ_AUTO_DIS_EN clears TX_EN after each command.
`ifndef TXRX_ADDR_W
`define TXRX_ADDR_W 4
`endif
`ifndef CH_IDX_W
`define CH_IDX_W 6
`endif
`ifndef TXRX_TX_EN
`define TXRX_TX_EN 0
`endif
`ifndef TXRX_TX_START
`define TXRX_TX_START 1
`endif
`ifndef TXRX_TX_READY
`define TXRX_TX_READY 2
`endif
`ifndef TXRX_TX_DATA
`define TXRX_TX_DATA 3
`endif
`ifndef TXRX_AA
`define TXRX_AA 4
`endif
`ifndef TXRX_CH_IDX
`define TXRX_CH_IDX 5
`endif

module txrx_seq #(
  parameter int ADDR_W    = `TXRX_ADDR_W,
  parameter int CH_IDX_W  = `CH_IDX_W,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_aa,
  input  logic [CH_IDX_W-1:0] cmd_ch_idx,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [7:0]          pl_data,
  input  logic                pl_valid,
  output logic                pl_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [31:0]         m_wdata,
  output logic                m_wstrb,
  input  logic [31:0]         m_rdata,
  input  logic                m_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [ADDR_W-1:0] A_EN    = ADDR_W'(`TXRX_TX_EN);
  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(`TXRX_TX_START);
  localparam logic [ADDR_W-1:0] A_READY = ADDR_W'(`TXRX_TX_READY);
  localparam logic [ADDR_W-1:0] A_DATA  = ADDR_W'(`TXRX_TX_DATA);
  localparam logic [ADDR_W-1:0] A_AA    = ADDR_W'(`TXRX_AA);
  localparam logic [ADDR_W-1:0] A_CH    = ADDR_W'(`TXRX_CH_IDX);

`ifdef TXRX_SEQ_AUTO_DIS_EN
  localparam logic AUTO_DIS = 1'b1;
`else
  localparam logic AUTO_DIS = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_POLL_IDLE, S_WR_AA, S_WR_CH, S_WR_TXEN, S_WR_DATA,
    S_WR_START1, S_WR_START0, S_POLL_BUSY, S_POLL_DONE, S_FIN, S_DONE
  } state_t;

  state_t                r_state, w_state, w_nxt, w_end;
  logic [31:0]           r_aa, w_aa;
  logic [CH_IDX_W-1:0]   r_ch, w_ch;
  logic [LEN_W-1:0]      r_cnt, w_cnt;
  logic [TIMEOUT_W-1:0]  r_tmo, w_tmo;
  logic                  r_to, w_to;
  logic                  r_mvalid, w_mvalid;
  logic [ADDR_W-1:0]     r_addr, w_addr, w_op_addr;
  logic [31:0]           r_wdata, w_wdata, w_op_data;
  logic                  r_wstrb, w_wstrb, w_op_wr;
  logic                  r_pl_ready, w_pl_ready;
  logic                  r_err, w_err;
  logic                  r_cmd_ready, r_busy, r_done;
  logic                  w_poll, w_sat;
  logic                  w_unused;

  assign w_unused = ^m_rdata[31:1];
  assign w_sat    = &r_tmo;
  assign w_poll   = (r_state == S_POLL_IDLE) || (r_state == S_POLL_BUSY) ||
                    (r_state == S_POLL_DONE);
  assign w_end    = AUTO_DIS ? S_FIN : S_DONE;

  // Per-state bus op and the state that follows its completion
  always_comb begin
    w_op_addr = A_READY;
    w_op_data = '0;
    w_op_wr   = 1'b0;
    w_nxt     = r_state;
    unique case (r_state)
      S_POLL_IDLE: w_nxt = m_rdata[0] ? S_WR_AA : S_POLL_IDLE;
      S_WR_AA:     begin w_op_addr = A_AA; w_op_data = r_aa; w_op_wr = 1'b1; w_nxt = S_WR_CH; end
      S_WR_CH:     begin w_op_addr = A_CH; w_op_data = 32'(r_ch); w_op_wr = 1'b1; w_nxt = S_WR_TXEN; end
      S_WR_TXEN:   begin w_op_addr = A_EN; w_op_data = 32'd1; w_op_wr = 1'b1; w_nxt = S_WR_DATA; end
      S_WR_DATA:   begin w_op_addr = A_DATA; w_op_data = {24'b0, pl_data}; w_op_wr = 1'b1; end
      S_WR_START1: begin w_op_addr = A_START; w_op_data = 32'd1; w_op_wr = 1'b1; w_nxt = S_WR_START0; end
      S_WR_START0: begin w_op_addr = A_START; w_op_wr = 1'b1; w_nxt = S_POLL_BUSY; end
      S_POLL_BUSY: w_nxt = m_rdata[0] ? S_POLL_BUSY : S_POLL_DONE;
      S_POLL_DONE: w_nxt = m_rdata[0] ? w_end : S_POLL_DONE;
      S_FIN:       begin w_op_addr = A_EN; w_op_wr = 1'b1; w_nxt = S_DONE; end
      default: ;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_aa       = r_aa;
    w_ch       = r_ch;
    w_cnt      = r_cnt;
    w_to       = r_to;
    w_mvalid   = r_mvalid;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_wstrb    = r_wstrb;
    w_pl_ready = 1'b0;
    w_err      = r_err;
    if (r_state == S_IDLE) begin
      if (cmd_valid && r_cmd_ready) begin
        w_aa    = cmd_aa;
        w_ch    = cmd_ch_idx;
        w_cnt   = cmd_len;
        w_to    = 1'b0;
        w_err   = 1'b0;
        w_state = S_POLL_IDLE;
      end
    end else if (r_state == S_DONE) begin
      w_state = S_IDLE;
    end else if (r_mvalid) begin
      if (m_ready) begin
        w_mvalid = 1'b0;
        w_state  = w_nxt;
        if (r_state == S_WR_DATA) w_cnt = r_cnt - LEN_W'(1);
        if (w_poll && w_nxt == r_state && w_sat) begin
          w_state = w_end;
          w_to    = 1'b1;
        end
      end
    end else if (w_poll && w_sat) begin
      w_state = w_end;
      w_to    = 1'b1;
    end else if (r_state == S_WR_DATA && r_cnt == '0) begin
      w_state = S_WR_START1;
    end else if (r_state != S_WR_DATA || pl_valid) begin
      w_mvalid   = 1'b1;
      w_addr     = w_op_addr;
      w_wdata    = w_op_data;
      w_wstrb    = w_op_wr;
      w_pl_ready = (r_state == S_WR_DATA);
    end
    if (w_state == S_DONE) w_err = w_to;
    // Timeout counter restarts on every state change
    if (w_state != r_state)   w_tmo = '0;
    else if (w_poll && !w_sat) w_tmo = r_tmo + TIMEOUT_W'(1);
    else                      w_tmo = r_tmo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_aa        <= '0;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_to        <= 1'b0;
      r_mvalid    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= 1'b0;
      r_pl_ready  <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_aa        <= w_aa;
      r_ch        <= w_ch;
      r_cnt       <= w_cnt;
      r_tmo       <= w_tmo;
      r_to        <= w_to;
      r_mvalid    <= w_mvalid;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_pl_ready  <= w_pl_ready;
      r_err       <= w_err;
      r_cmd_ready <= (w_state == S_IDLE);
      r_busy      <= (w_state != S_IDLE);
      r_done      <= (w_state == S_DONE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign pl_ready  = r_pl_ready;
  assign m_valid   = r_mvalid;
  assign m_address = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_txrx_seq.sv
// Directed bench for txrx_seq with a 1-cycle txrx responder model.
// A second instance with TIMEOUT_W=4 covers the poll timeout path.
module tb_txrx_seq;
  localparam int AW = 4;
  localparam int CW = 6;
  localparam logic [3:0] A_EN = 4'd0, A_START = 4'd1, A_DATA = 4'd3;
  localparam logic [3:0] A_AA = 4'd4, A_CH = 4'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic cmd_valid, cmd_ready, cmd_valid2, cmd_ready2;
  logic [31:0] cmd_aa;
  logic [CW-1:0] cmd_ch_idx;
  logic [7:0] cmd_len, pl_data;
  logic pl_valid, pl_ready, pl_ready2;
  logic m_valid, m_wstrb, m_ready, m_valid2, m_wstrb2, m_ready2;
  logic [AW-1:0] m_address, m_address2;
  logic [31:0] m_wdata, m_rdata, m_wdata2, m_rdata2;
  logic busy, done, err, busy2, done2, err2;

  txrx_seq #(.ADDR_W(AW), .CH_IDX_W(CW), .LEN_W(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_aa(cmd_aa), .cmd_ch_idx(cmd_ch_idx), .cmd_len(cmd_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err));

  txrx_seq #(.ADDR_W(AW), .CH_IDX_W(CW), .LEN_W(8), .TIMEOUT_W(4)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_aa(cmd_aa), .cmd_ch_idx(cmd_ch_idx), .cmd_len(cmd_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready2),
    .m_valid(m_valid2), .m_address(m_address2), .m_wdata(m_wdata2),
    .m_wstrb(m_wstrb2), .m_rdata(m_rdata2), .m_ready(m_ready2),
    .busy(busy2), .done(done2), .err(err2));

  // responder / payload source model
  int bcnt = 0;
  int pl_idx = 0, pl_start = 0, pl_end = 0, stall = 0, stall_len = 0;
  logic [7:0] pl_tag = 8'h00;
  always @(posedge clk) begin
    m_ready <= m_valid;
    m_ready2 <= m_valid2;
    if (m_valid && m_ready && m_wstrb && m_address == A_START && m_wdata == 32'd1)
      bcnt <= 20;
    else if (bcnt != 0)
      bcnt <= bcnt - 1;
    if (pl_ready) begin
      pl_idx <= pl_idx + 1;
      if (pl_idx == pl_start) stall <= stall_len;
    end else if (stall != 0) begin
      stall <= stall - 1;
    end
  end
  assign m_rdata  = {31'h7FFFFFFF, bcnt == 0};
  assign m_rdata2 = 32'hFFFFFFFE;
  assign pl_valid = (pl_idx < pl_end) && (stall == 0);
  assign pl_data  = pl_tag + 8'(pl_idx - pl_start);

  // bus monitor
  logic [35:0] wlog[$], w2log[$];
  int n_viol = 0, n_srise = 0, n_plr = 0, n_done = 0, n_acc = 0, vrun = 0;
  logic prev_hs = 1'b0, prev_v = 1'b0;
  logic [36:0] prev_op = '0;
  always @(negedge clk) begin
    if (m_valid && m_ready && m_wstrb) wlog.push_back({m_address, m_wdata});
    if (m_valid && prev_hs) n_viol++;
    if (m_valid && prev_v && !prev_hs && {m_address, m_wdata, m_wstrb} != prev_op) n_viol++;
    vrun = m_valid ? vrun + 1 : 0;
    if (vrun > 2) n_viol++;
    if (m_valid && !prev_v && stall != 0) n_srise++;
    if (pl_ready) n_plr++;
    if (done) n_done++;
    prev_hs = m_valid && m_ready;
    prev_v  = m_valid;
    prev_op = {m_address, m_wdata, m_wstrb};
    if (m_valid2 && m_ready2 && m_wstrb2) w2log.push_back({m_address2, m_wdata2});
  end
  always @(posedge clk) if (cmd_valid && cmd_ready) n_acc++;

  int n_tests = 0, n_fail = 0;

  task automatic send_cmd(input bit d2, input logic [31:0] aa, input logic [CW-1:0] ch,
                          input logic [7:0] len, input logic [7:0] tag, input int slen);
    @(negedge clk);
    pl_start = pl_idx; pl_end = pl_idx + int'(len); pl_tag = tag; stall_len = slen;
    cmd_aa = aa; cmd_ch_idx = ch; cmd_len = len;
    if (d2) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_aa = 32'hDEADBEEF; cmd_ch_idx = '1; cmd_len = 8'hFF;
  endtask

  task automatic wait_done(input bit d2, input int lim, output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < lim) begin
      @(negedge clk); cyc++;
      if (d2 ? done2 : done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_aa = '0; cmd_ch_idx = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_mvalid got %b exp 0", m_valid); end
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_cmd_ready got %b exp 1", cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    n_tests++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_status got %b exp 000", {busy, done, err}); end
    n_tests++; if ({m_valid, m_wstrb, pl_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_bus got %b exp 000", {m_valid, m_wstrb, pl_ready}); end
    n_tests++; if ({m_address, m_wdata} !== 36'h0) begin n_fail++; $display("FAIL rst_addr_data got %h exp 0", {m_address, m_wdata}); end
  endtask

  task automatic test_basic;
    logic [35:0] exp[$];
    int s, p, d, v, cyc; bit ok;
    s = wlog.size(); p = n_plr; d = n_done; v = n_viol;
    exp.push_back({A_AA, 32'h8E89BED6}); exp.push_back({A_CH, 32'h5});
    exp.push_back({A_EN, 32'h1}); exp.push_back({A_DATA, 32'hA1});
    exp.push_back({A_DATA, 32'hA2}); exp.push_back({A_DATA, 32'hA3});
    exp.push_back({A_START, 32'h1}); exp.push_back({A_START, 32'h0});
`ifdef TXRX_SEQ_AUTO_DIS_EN
    exp.push_back({A_EN, 32'h0});
`endif
    send_cmd(1'b0, 32'h8E89BED6, 6'd5, 8'd3, 8'hA1, 0);
    wait_done(1'b0, 400, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_done got timeout exp done within 400"); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", err); end
    repeat (5) @(negedge clk);
    n_tests++; if (n_done - d != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d exp 1", n_done - d); end
    n_tests++; if (wlog.size() - s != exp.size()) begin n_fail++; $display("FAIL basic_nwrites got %0d exp %0d", wlog.size() - s, exp.size()); end
    for (int i = 0; i < exp.size() && s + i < wlog.size(); i++) begin
      n_tests++; if (wlog[s + i] !== exp[i]) begin n_fail++; $display("FAIL basic_wr%0d got %h exp %h", i, wlog[s + i], exp[i]); end
    end
    n_tests++; if (n_plr - p != 3) begin n_fail++; $display("FAIL basic_pl_ready got %0d exp 3", n_plr - p); end
    n_tests++; if (n_viol != v) begin n_fail++; $display("FAIL basic_op_timing got %0d viol exp 0", n_viol - v); end
    n_tests++; if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL basic_idle got %b exp 10", {cmd_ready, busy}); end
  endtask

  task automatic test_len0;
    logic [35:0] exp[$];
    int s, p, cyc; bit ok;
    s = wlog.size(); p = n_plr;
    exp.push_back({A_AA, 32'h12345678}); exp.push_back({A_CH, 32'h2A});
    exp.push_back({A_EN, 32'h1});
    exp.push_back({A_START, 32'h1}); exp.push_back({A_START, 32'h0});
`ifdef TXRX_SEQ_AUTO_DIS_EN
    exp.push_back({A_EN, 32'h0});
`endif
    send_cmd(1'b0, 32'h12345678, 6'h2A, 8'd0, 8'h00, 0);
    wait_done(1'b0, 400, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL len0_done got timeout exp done within 400"); end
    n_tests++; if (wlog.size() - s != exp.size()) begin n_fail++; $display("FAIL len0_nwrites got %0d exp %0d", wlog.size() - s, exp.size()); end
    for (int i = 0; i < exp.size() && s + i < wlog.size(); i++) begin
      n_tests++; if (wlog[s + i] !== exp[i]) begin n_fail++; $display("FAIL len0_wr%0d got %h exp %h", i, wlog[s + i], exp[i]); end
    end
    n_tests++; if (n_plr != p) begin n_fail++; $display("FAIL len0_pl_ready got %0d exp 0", n_plr - p); end
  endtask

  task automatic test_stall;
    logic [35:0] exp[$];
    int s, p, r, v, cyc; bit ok;
    s = wlog.size(); p = n_plr; r = n_srise; v = n_viol;
    exp.push_back({A_AA, 32'hCAFEF00D}); exp.push_back({A_CH, 32'h1});
    exp.push_back({A_EN, 32'h1}); exp.push_back({A_DATA, 32'hB1});
    exp.push_back({A_DATA, 32'hB2});
    exp.push_back({A_START, 32'h1}); exp.push_back({A_START, 32'h0});
`ifdef TXRX_SEQ_AUTO_DIS_EN
    exp.push_back({A_EN, 32'h0});
`endif
    send_cmd(1'b0, 32'hCAFEF00D, 6'd1, 8'd2, 8'hB1, 10);
    wait_done(1'b0, 400, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_done got timeout exp done within 400"); end
    n_tests++; if (n_plr - p != 2) begin n_fail++; $display("FAIL stall_pl_ready got %0d exp 2", n_plr - p); end
    n_tests++; if (n_srise != r) begin n_fail++; $display("FAIL stall_mvalid got %0d rises exp 0", n_srise - r); end
    n_tests++; if (n_viol != v) begin n_fail++; $display("FAIL stall_op_timing got %0d viol exp 0", n_viol - v); end
    n_tests++; if (wlog.size() - s != exp.size()) begin n_fail++; $display("FAIL stall_nwrites got %0d exp %0d", wlog.size() - s, exp.size()); end
    for (int i = 0; i < exp.size() && s + i < wlog.size(); i++) begin
      n_tests++; if (wlog[s + i] !== exp[i]) begin n_fail++; $display("FAIL stall_wr%0d got %h exp %h", i, wlog[s + i], exp[i]); end
    end
  endtask

  task automatic test_busy_accept;
    int a, s2, cyc; bit ok;
    logic [35:0] last_exp;
`ifdef TXRX_SEQ_AUTO_DIS_EN
    last_exp = {A_EN, 32'h0};
`else
    last_exp = {A_START, 32'h0};
`endif
    send_cmd(1'b0, 32'h11112222, 6'd9, 8'd1, 8'hC1, 0);
    @(negedge clk);
    pl_end = pl_end + 1;
    cmd_aa = 32'h55AA55AA; cmd_ch_idx = 6'd10; cmd_len = 8'd1; cmd_valid = 1'b1;
    a = n_acc;
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_cmd_ready got %b exp 0", cmd_ready); end
    wait_done(1'b0, 400, ok, cyc);
    s2 = wlog.size();
    n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_done1 got timeout exp done within 400"); end
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready_at_done got %b exp 0", cmd_ready); end
    n_tests++; if (n_acc != a) begin n_fail++; $display("FAIL busy_no_accept got %0d exp 0", n_acc - a); end
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready_after_done got %b exp 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_aa = 32'hDEADBEEF;
    n_tests++; if (n_acc - a != 1) begin n_fail++; $display("FAIL busy_accept got %0d exp 1", n_acc - a); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept got %b exp 1", busy); end
    wait_done(1'b0, 400, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_done2 got timeout exp done within 400"); end
    if (s2 > 0 && s2 < wlog.size()) begin
      n_tests++; if (wlog[s2 - 1] !== last_exp) begin n_fail++; $display("FAIL busy_last1 got %h exp %h", wlog[s2 - 1], last_exp); end
      n_tests++; if (wlog[s2] !== {A_AA, 32'h55AA55AA}) begin n_fail++; $display("FAIL busy_aa2 got %h exp %h", wlog[s2], {A_AA, 32'h55AA55AA}); end
      n_tests++; if (wlog[wlog.size() - 1] !== last_exp) begin n_fail++; $display("FAIL busy_last2 got %h exp %h", wlog[wlog.size() - 1], last_exp); end
    end else begin
      n_tests++; n_fail++; $display("FAIL busy_log got %0d entries exp more than %0d", wlog.size(), s2);
    end
  endtask

  task automatic test_reset_mid;
    logic [35:0] exp[$];
    int s, cyc; bit ok, hit;
    send_cmd(1'b0, 32'h01020304, 6'd7, 8'd4, 8'hD1, 0);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (m_valid && m_address == A_DATA && m_wdata == 32'hD2) hit = 1'b1;
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rmid_reach got none exp TX_DATA D2 op"); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if ({m_valid, pl_ready, busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_async got %b exp 000", {m_valid, pl_ready, busy}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_tests++; if ({cmd_ready, busy, err} !== 3'b100) begin n_fail++; $display("FAIL rmid_after got %b exp 100", {cmd_ready, busy, err}); end
    s = wlog.size();
    exp.push_back({A_AA, 32'hA5A5A5A5}); exp.push_back({A_CH, 32'h3});
    exp.push_back({A_EN, 32'h1}); exp.push_back({A_DATA, 32'hE1});
    exp.push_back({A_START, 32'h1}); exp.push_back({A_START, 32'h0});
`ifdef TXRX_SEQ_AUTO_DIS_EN
    exp.push_back({A_EN, 32'h0});
`endif
    send_cmd(1'b0, 32'hA5A5A5A5, 6'd3, 8'd1, 8'hE1, 0);
    wait_done(1'b0, 400, ok, cyc);
    n_tests++; if (!ok || err !== 1'b0) begin n_fail++; $display("FAIL rmid_fresh got ok=%b err=%b exp ok=1 err=0", ok, err); end
    n_tests++; if (wlog.size() - s != exp.size()) begin n_fail++; $display("FAIL rmid_nwrites got %0d exp %0d", wlog.size() - s, exp.size()); end
    for (int i = 0; i < exp.size() && s + i < wlog.size(); i++) begin
      n_tests++; if (wlog[s + i] !== exp[i]) begin n_fail++; $display("FAIL rmid_wr%0d got %h exp %h", i, wlog[s + i], exp[i]); end
    end
  endtask

  task automatic test_timeout;
    int s, lo, hi, naa, nw, cyc; bit ok;
`ifdef TXRX_SEQ_AUTO_DIS_EN
    lo = 19; hi = 21; nw = 1;
`else
    lo = 16; hi = 18; nw = 0;
`endif
    s = w2log.size();
    send_cmd(1'b1, 32'h77777777, 6'd2, 8'd0, 8'h00, 0);
    wait_done(1'b1, 80, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_done got timeout exp done within 80"); end
    n_tests++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", err2); end
    n_tests++; if (cyc < lo || cyc > hi) begin n_fail++; $display("FAIL to_latency got %0d exp %0d..%0d", cyc, lo, hi); end
    naa = 0;
    for (int i = s; i < w2log.size(); i++) if (w2log[i][35:32] == A_AA) naa++;
    n_tests++; if (naa != 0) begin n_fail++; $display("FAIL to_no_aa got %0d exp 0", naa); end
    n_tests++; if (w2log.size() - s != nw) begin n_fail++; $display("FAIL to_nwrites got %0d exp %0d", w2log.size() - s, nw); end
    @(negedge clk);
    n_tests++; if ({cmd_ready2, err2} !== 2'b11) begin n_fail++; $display("FAIL to_err_held got %b exp 11", {cmd_ready2, err2}); end
    send_cmd(1'b1, 32'h77777777, 6'd2, 8'd0, 8'h00, 0);
    @(negedge clk);
    n_tests++; if ({busy2, err2} !== 2'b10) begin n_fail++; $display("FAIL to_err_clear got %b exp 10", {busy2, err2}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_busy_accept();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/txrx_seq.md
Name: txrx_seq

Overview:
- Hardware bus initiator that drives the txrx CPU register port autonomously. It sends one packet per command without CPU involvement.
- Per command it:
  - waits for the transmitter to be idle;
  - programs the access address, channel index and TX enable;
  - streams cmd_len payload bytes from a byte-stream source into TX_DATA;
  - pulses TX_START;
  - polls TX_READY until transmission completes.
- Sits between a packet producer (DMA/FIFO) and txrx, muxed with the CPU on the txrx slave port.

Parameters:
- ADDR_W, `TXRX_ADDR_W: register address width.
- CH_IDX_W, `CH_IDX_W: channel index width.
- LEN_W, 8: payload length field width; maximum 255 bytes.
- TIMEOUT_W, 16: poll timeout counter width; timeout is 2^TIMEOUT_W-1 cycles per poll phase.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted on cmd_valid&cmd_ready
- cmd_aa  in  32  access address for the packet
- cmd_ch_idx  in  CH_IDX_W  channel index
- cmd_len  in  LEN_W  payload byte count
- pl_data  in  8  payload byte
- pl_valid  in  1  payload byte available
- pl_ready  out  1  one-cycle pulse; byte consumed
- m_valid  out  1  bus request to txrx
- m_address  out  ADDR_W  register address (txrx.vh map macros)
- m_wdata  out  32  write data
- m_wstrb  out  1  1=write, 0=read
- m_rdata  in  32  read data, valid when m_ready=1
- m_ready  in  1  transaction complete
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at end of each command
- err  out  1  set with done on timeout; held until next command is accepted

Behaviour:
- Reset:
  - all outputs 0, except cmd_ready=1.
  - FSM returns to IDLE; counters and captured command cleared.
- Reset mid-operation:
  - m_valid drops immediately (asynchronous); no partial op is retried.
- All outputs are registered.
- Bus op rules:
  - m_valid, m_address, m_wdata and m_wstrb are held stable until the cycle m_ready=1.
  - m_valid falls on the following edge.
  - At least one m_valid=0 cycle is mandatory between ops.
  - m_ready is ignored while m_valid=0 (the stale ready from txrx lands in the idle cycle).
  - Against the 1-cycle txrx responder, each op costs exactly 3 cycles.
  - Reads capture m_rdata[0] in the m_ready cycle.
- Command capture: on accept, cmd_aa, cmd_ch_idx and cmd_len are registered; the inputs may change afterwards.
- FSM:
  - IDLE: on accept, go to POLL_IDLE.
  - POLL_IDLE: read TX_READY; repeat until 1, then go to WR_AA.
  - WR_AA: write TXRX_AA with the captured aa.
  - WR_CH: write TXRX_CH_IDX with the captured ch_idx, zero-extended.
  - WR_TXEN: write TX_EN with 1.
  - WR_DATA:
    - If remaining count=0, go to WR_START1.
    - Otherwise wait for pl_valid; in the capture cycle assert pl_ready=1, load {24'b0,pl_data} into m_wdata and raise m_valid to TX_DATA.
    - Decrement the count on m_ready.
    - pl_valid low only stalls; there is no timeout here.
  - WR_START1: write TX_START with 1.
  - WR_START0: write TX_START with 0 (txrx detects the rising edge, so this sequence is a single start).
  - POLL_BUSY: read TX_READY until 0 (transmission began).
  - POLL_DONE: read TX_READY until 1.
  - FIN (optional feature below), then DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- cmd_len=0: no TX_DATA writes; a header-only packet is started.
- Timeout:
  - Applies to each of POLL_IDLE, POLL_BUSY and POLL_DONE.
  - Counter cleared on entry to each poll state; counts every cycle spent in it.
  - At saturation, finish the current op, skip to DONE with err=1. A started TX_START write sequence is always completed first.
- Bus acceptance: cmd_valid while busy is not accepted; cmd_ready=0.
- done and new accept: cmd_ready rises in the cycle after the done pulse.

Optional Feature:
- Macro: TXRX_SEQ_AUTO_DIS_EN.
- Defined: FIN performs one write of TX_EN=0 after POLL_DONE, and also on the timeout path, to power down the transmitter. It adds 3 cycles per command.
- Undefined: FIN is skipped and tx_en stays 1 after the command.

Test Plan:
- Reset during WR_DATA (byte 2 of 4) -> m_valid=0 immediately; after release cmd_ready=1, busy=0, err=0; a fresh command completes normally.
- Model txrx responder: TX_READY=1 initially; cmd aa=32'h8E89BED6, ch=5, len=3, bytes 8'hA1,8'hA2,8'hA3 always valid -> bus write order and addresses:
  - AA=8E89BED6
  - CH_IDX=5
  - TX_EN=1
  - TX_DATA=A1, A2, A3
  - TX_START=1
  - TX_START=0

  Responder then drops TX_READY for 20 cycles -> single done pulse, err=0. Each op is 3 cycles with one idle gap.
- len=0 -> no TX_DATA write; TX_START 1 then 0 directly after TX_EN; done=1.
- pl_valid low 10 cycles between bytes 1 and 2 of len=2 -> m_valid stays 0 during the stall; exactly 2 TX_DATA writes; pl_ready pulses exactly twice.
- TX_READY stuck at 0, TIMEOUT_W=4 -> exits POLL_IDLE after 15 cycles; no AA write; done=1 with err=1; err clears on the next accepted command.
- cmd_valid asserted while busy -> not accepted (cmd_ready=0); accepted the cycle after done. With TXRX_SEQ_AUTO_DIS_EN defined, the last write of each command is TX_EN=0.
